sram_client_scheduler: RTL and testbench

//  Shares one toggle-handshake SRAM arbiter port among NCLIENTS requesters (e.g. CPU DMA, RPi bridge, audio).

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_client_scheduler_rr_pick.sv | 31 +++
 rtl/sram_client_scheduler.sv | 171 +++++++++++++++++
 tb/tb_sram_client_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM widths, scheduler state encoding and the toggle-handshake helper.
package sram_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WACK  = 3'd2;
    localparam logic [2:0] ST_WDATA = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WACK  = ST_WACK,
        WDATA = ST_WDATA,
        DONE  = ST_DONE
    } state_t;

    // A toggle handshake has work outstanding whenever the two sides disagree.
    function automatic logic toggle_pending(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/sram_client_scheduler_rr_pick.sv
// Round-robin search over clients 1..NCLIENTS-1, starting at the pointer and
// wrapping back to client 1; client 0 is never considered here.
module rr_pick
    import sram_pkg::*;
#(
    parameter int NCLIENTS = 3,
    parameter int IW       = 2
) (
    input  logic [NCLIENTS-1:1] i_pending,
    input  logic [IW-1:0]       i_ptr,
    output logic                o_valid,
    output logic [IW-1:0]       o_idx
);

    logic [IW-1:0] w_cand;

    // Walk the candidates in rotated order and keep the first pending one.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NCLIENTS - 1; k++) begin
            w_cand = IW'((int'(i_ptr) + NCLIENTS - 2 + k) % (NCLIENTS - 1) + 1);
            if (!o_valid && i_pending[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/sram_client_scheduler.sv
// Shares one toggle-handshake SRAM port among NCLIENTS requesters. Client 0 has
// priority, limited by a starvation counter; the rest are served round-robin.
module sram_client_scheduler
    import sram_pkg::*;
#(
    parameter int NCLIENTS = 3,
    parameter int RD_LAT   = 4,
    parameter int MAX_WAIT = 7
) (
    input  logic                        clk200,
    input  logic                        reset_n,
    input  logic [NCLIENTS-1:0]         cl_req,
    output logic [NCLIENTS-1:0]         cl_ack,
    input  logic [NCLIENTS-1:0]         cl_read,
    input  logic [NCLIENTS*SRAM_AW-1:0] cl_address,
    input  logic [NCLIENTS-1:0]         cl_lb,
    input  logic [NCLIENTS-1:0]         cl_ub,
    input  logic [NCLIENTS*SRAM_DW-1:0] cl_wdata,
    output logic [SRAM_DW-1:0]          cl_rdata,
    output logic [NCLIENTS-1:0]         cl_rvalid,
    output logic                        m_req,
    input  logic                        m_ack,
    output logic                        m_read,
    output logic                        m_lb,
    output logic                        m_ub,
    output logic [SRAM_AW-1:0]          m_address,
    output logic [SRAM_DW-1:0]          m_wdata,
    input  logic [SRAM_DW-1:0]          m_rdata
);

    localparam int IW = (NCLIENTS > 2) ? 2 : 1;
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t                r_state;
    logic [IW-1:0]         r_gnt;
    logic [IW-1:0]         r_rrPtr;
    logic [SW-1:0]         r_starveCnt;
    logic [LW-1:0]         r_latCnt;
    logic [NCLIENTS-1:0]   r_clAck;
    logic [NCLIENTS-1:0]   r_clRvalid;
    logic [SRAM_DW-1:0]    r_clRdata;
    logic                  r_mReq;
    logic                  r_mRead;
    logic                  r_mLb;
    logic                  r_mUb;
    logic [SRAM_AW-1:0]    r_mAddress;
    logic [SRAM_DW-1:0]    r_mWdata;

    logic [NCLIENTS-1:0]   w_pending;
    logic                  w_otherPending;
    logic                  w_grant0;
    logic                  w_rrValid;
    logic [IW-1:0]         w_rrIdx;
    logic [IW-1:0]         w_selIdx;
    logic                  w_selRead;
    logic                  w_selLb;
    logic                  w_selUb;
    logic [SRAM_AW-1:0]    w_selAddr;
    logic [SRAM_DW-1:0]    w_selWdata;

    // Per-client pending flags and the client-0 priority decision.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NCLIENTS; i++) begin
            w_pending[i] = toggle_pending(cl_req[i], r_clAck[i]);
        end
        w_otherPending = |w_pending[NCLIENTS-1:1];
        w_grant0 = w_pending[0] && (!w_otherPending || (r_starveCnt < SW'(MAX_WAIT)));
    end

    rr_pick #(
        .NCLIENTS (NCLIENTS),
        .IW       (IW)
    ) u_rrPick (
        .i_pending (w_pending[NCLIENTS-1:1]),
        .i_ptr     (r_rrPtr),
        .o_valid   (w_rrValid),
        .o_idx     (w_rrIdx)
    );

    // Select the command fields of whichever client would be granted this cycle.
    always_comb begin
        w_selIdx   = w_grant0 ? '0 : w_rrIdx;
        w_selRead  = cl_read[w_selIdx];
        w_selLb    = cl_lb[w_selIdx];
        w_selUb    = cl_ub[w_selIdx];
        w_selAddr  = cl_address[SRAM_AW*w_selIdx +: SRAM_AW];
        w_selWdata = cl_wdata[SRAM_DW*w_selIdx +: SRAM_DW];
    end

    // Scheduler FSM: grant, issue one downstream toggle, wait ack plus latency, complete.
    always_ff @(posedge clk200 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rrPtr     <= IW'(1);
            r_starveCnt <= '0;
            r_latCnt    <= '0;
            r_clAck     <= '0;
            r_clRvalid  <= '0;
            r_clRdata   <= '0;
            r_mReq      <= 1'b0;
            r_mRead     <= 1'b0;
            r_mLb       <= 1'b0;
            r_mUb       <= 1'b0;
            r_mAddress  <= '0;
            r_mWdata    <= '0;
        end else begin
            r_clRvalid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_rrValid) begin
                        r_gnt      <= w_selIdx;
                        r_mRead    <= w_selRead;
                        r_mLb      <= w_selLb;
                        r_mUb      <= w_selUb;
                        r_mAddress <= w_selAddr;
                        r_mWdata   <= w_selWdata;
                        r_state    <= ISSUE;
                        if (w_grant0) begin
                            r_starveCnt <= w_otherPending ? (r_starveCnt + SW'(1)) : '0;
                        end else begin
                            r_starveCnt <= '0;
                            r_rrPtr     <= (w_rrIdx == IW'(NCLIENTS - 1)) ? IW'(1) : (w_rrIdx + IW'(1));
                        end
                    end
                end
                ISSUE: begin
                    r_mReq  <= ~r_mReq;
                    r_state <= WACK;
                end
                WACK: begin
                    if (m_ack == r_mReq) begin
                        r_latCnt <= LW'(RD_LAT - 1);
                        r_state  <= WDATA;
                    end
                end
                WDATA: begin
                    if (r_latCnt == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_latCnt <= r_latCnt - LW'(1);
                    end
                end
                DONE: begin
                    r_clAck[r_gnt] <= cl_req[r_gnt];
                    if (r_mRead) begin
                        r_clRdata         <= m_rdata;
                        r_clRvalid[r_gnt] <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cl_ack    = r_clAck;
    assign cl_rvalid = r_clRvalid;
    assign cl_rdata  = r_clRdata;
    assign m_req     = r_mReq;
    assign m_read    = r_mRead;
    assign m_lb      = r_mLb;
    assign m_ub      = r_mUb;
    assign m_address = r_mAddress;
    assign m_wdata   = r_mWdata;

endmodule

// File: tb/tb_sram_client_scheduler.sv
// Directed bench for sram_client_scheduler: a vector table for single accesses
// plus hand-written sequences for contention, starvation and mid-access reset.
module tb_sram_client_scheduler;

    localparam int NCLIENTS = 3;
    localparam int RD_LAT   = 4;
    localparam int MAX_WAIT = 7;

    logic                 clk200 = 1'b0;
    logic                 reset_n;
    logic [NCLIENTS-1:0]  cl_req;
    logic [NCLIENTS-1:0]  cl_ack;
    logic [NCLIENTS-1:0]  cl_read;
    logic [NCLIENTS*20-1:0] cl_address;
    logic [NCLIENTS-1:0]  cl_lb;
    logic [NCLIENTS-1:0]  cl_ub;
    logic [NCLIENTS*16-1:0] cl_wdata;
    logic [15:0]          cl_rdata;
    logic [NCLIENTS-1:0]  cl_rvalid;
    logic                 m_req;
    wire                  m_ack;
    logic                 m_read;
    logic                 m_lb;
    logic                 m_ub;
    logic [19:0]          m_address;
    logic [15:0]          m_wdata;
    logic [15:0]          m_rdata;
    logic [15:0]          modelRdata;

    int assertCount = 0;
    int failCount   = 0;
    int grantLog[$];

    typedef struct {
        int          client;
        logic        isRead;
        logic [19:0] addr;
        logic        lb;
        logic        ub;
        logic [15:0] wdata;
        logic [15:0] modelData;
        logic        expRead;
        logic        expLb;
        logic        expUb;
        logic [19:0] expAddr;
        logic [15:0] expWdata;
        logic [2:0]  expRvalid;
        logic [15:0] expRdata;
    } vec_t;

    vec_t vecs[6];

    sram_client_scheduler #(
        .NCLIENTS (NCLIENTS),
        .RD_LAT   (RD_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk200     (clk200),
        .reset_n    (reset_n),
        .cl_req     (cl_req),
        .cl_ack     (cl_ack),
        .cl_read    (cl_read),
        .cl_address (cl_address),
        .cl_lb      (cl_lb),
        .cl_ub      (cl_ub),
        .cl_wdata   (cl_wdata),
        .cl_rdata   (cl_rdata),
        .cl_rvalid  (cl_rvalid),
        .m_req      (m_req),
        .m_ack      (m_ack),
        .m_read     (m_read),
        .m_lb       (m_lb),
        .m_ub       (m_ub),
        .m_address  (m_address),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata)
    );

    always #5 clk200 = ~clk200;

    // Downstream arbiter acknowledges with zero delay and shares the reset.
    assign m_ack = m_req;

    // Read data is garbage until RD_LAT cycles after the ack toggle.
    initial begin
        m_rdata = 16'hDEAD;
        forever begin
            @(m_req);
            m_rdata = 16'hDEAD;
            repeat (RD_LAT) @(posedge clk200);
            m_rdata = modelRdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One uncontended access: drive the client, then watch latency, command and read return.
    task automatic applyStimulus(input vec_t v);
        int   cycles;
        int   toggles;
        bit   done;
        bit   early;
        logic prevReq;
        @(negedge clk200);
        cl_read[v.client]             = v.isRead;
        cl_lb[v.client]               = v.lb;
        cl_ub[v.client]               = v.ub;
        cl_address[20*v.client +: 20] = v.addr;
        cl_wdata[16*v.client +: 16]   = v.wdata;
        modelRdata                    = v.modelData;
        cl_req[v.client]              = ~cl_req[v.client];
        cycles  = 0;
        toggles = 0;
        done    = 1'b0;
        early   = 1'b0;
        prevReq = m_req;
        while (!done && cycles < 40) begin
            @(negedge clk200);
            cycles++;
            if (m_req !== prevReq) toggles++;
            prevReq = m_req;
            if (cl_ack[v.client] === cl_req[v.client]) done = 1'b1;
            else if (cl_rvalid !== '0) early = 1'b1;
        end
        checkOutput("grant-to-ack latency", cycles - 1, 3 + RD_LAT);
        checkOutput("m_req toggle count", toggles, 1);
        checkOutput("early rvalid", early, 0);
        checkOutput("m_read", m_read, v.expRead);
        checkOutput("m_lb", m_lb, v.expLb);
        checkOutput("m_ub", m_ub, v.expUb);
        checkOutput("m_address", m_address, v.expAddr);
        checkOutput("m_wdata", m_wdata, v.expWdata);
        checkOutput("cl_rvalid at ack", cl_rvalid, v.expRvalid);
        checkOutput("cl_rdata at ack", cl_rdata, v.expRdata);
        @(negedge clk200);
        checkOutput("cl_rvalid after pulse", cl_rvalid, 0);
        checkOutput("cl_rdata held", cl_rdata, v.expRdata);
    endtask

    // Keep the masked clients continuously pending and log who each grant went to.
    task automatic runContention(input logic [NCLIENTS-1:0] mask, input int nGrants);
        int   cycles;
        logic prevReq;
        grantLog.delete();
        @(negedge clk200);
        for (int c = 0; c < NCLIENTS; c++) begin
            if (mask[c]) begin
                cl_read[c]          = 1'b0;
                cl_address[20*c +: 20] = 20'h10000 + 20'(c);
                cl_req[c]           = ~cl_req[c];
            end
        end
        prevReq = m_req;
        cycles  = 0;
        while (grantLog.size() < nGrants && cycles < 2000) begin
            @(negedge clk200);
            cycles++;
            if (m_req !== prevReq) begin
                grantLog.push_back(int'(m_address[3:0]));
                prevReq = m_req;
            end
            for (int c = 0; c < NCLIENTS; c++) begin
                if (mask[c] && cl_ack[c] === cl_req[c] && grantLog.size() < nGrants)
                    cl_req[c] = ~cl_req[c];
            end
        end
        checkOutput("contention grants recorded", grantLog.size(), nGrants);
        cycles = 0;
        while (cl_ack !== cl_req && cycles < 200) begin
            @(negedge clk200);
            cycles++;
        end
        checkOutput("contention drained", (cl_ack === cl_req), 1);
    endtask

    initial begin
        int   exp4[6];
        int   cycles;
        logic prevReq;

        vecs[0] = '{1, 1'b1, 20'h00123, 1'b1, 1'b1, 16'h0000, 16'hBEEF,
                    1'b1, 1'b1, 1'b1, 20'h00123, 16'h0000, 3'b010, 16'hBEEF};
        vecs[1] = '{2, 1'b0, 20'h1C0DE, 1'b1, 1'b0, 16'h5AA5, 16'h0BAD,
                    1'b0, 1'b1, 1'b0, 20'h1C0DE, 16'h5AA5, 3'b000, 16'hBEEF};
        vecs[2] = '{0, 1'b1, 20'h0ABCD, 1'b1, 1'b1, 16'h3333, 16'h1234,
                    1'b1, 1'b1, 1'b1, 20'h0ABCD, 16'h3333, 3'b001, 16'h1234};
        vecs[3] = '{0, 1'b0, 20'hFFFFF, 1'b0, 1'b1, 16'hFFFF, 16'h0BAD,
                    1'b0, 1'b0, 1'b1, 20'hFFFFF, 16'hFFFF, 3'b000, 16'h1234};
        vecs[4] = '{2, 1'b1, 20'h00000, 1'b0, 1'b0, 16'hC0C0, 16'h8001,
                    1'b1, 1'b0, 1'b0, 20'h00000, 16'hC0C0, 3'b100, 16'h8001};
        vecs[5] = '{1, 1'b1, 20'h00003, 1'b1, 1'b1, 16'h0000, 16'h7E57,
                    1'b1, 1'b1, 1'b1, 20'h00003, 16'h0000, 3'b010, 16'h7E57};
        exp4 = '{1, 2, 1, 2, 1, 2};

        // Reset held with every client requesting.
        reset_n    = 1'b0;
        cl_req     = '1;
        cl_read    = '0;
        cl_lb      = '0;
        cl_ub      = '0;
        cl_address = '0;
        cl_wdata   = '0;
        modelRdata = 16'h0000;
        repeat (4) begin
            @(negedge clk200);
            checkOutput("reset cl_ack", cl_ack, 0);
            checkOutput("reset m_req", m_req, 0);
            checkOutput("reset cl_rvalid", cl_rvalid, 0);
        end
        checkOutput("reset cl_rdata", cl_rdata, 0);
        checkOutput("reset m_address", m_address, 0);
        checkOutput("reset m_wdata", m_wdata, 0);
        checkOutput("reset m_read/lb/ub", {m_read, m_lb, m_ub}, 0);
        cl_req = '0;
        @(negedge clk200);
        reset_n = 1'b1;
        repeat (3) @(negedge clk200);
        checkOutput("idle no toggle", m_req, 0);

        $display("[TB] single-access vectors");
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        $display("[TB] round-robin between clients 1 and 2");
        runContention(3'b110, 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("rr grant %0d", i), (i < grantLog.size()) ? grantLog[i] : -1, exp4[i]);

        $display("[TB] client 0 starvation bound");
        runContention(3'b011, 16);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("starve grant %0d", i), (i < grantLog.size()) ? grantLog[i] : -1,
                        (i % (MAX_WAIT + 1) == MAX_WAIT) ? 1 : 0);

        $display("[TB] reset during data wait");
        @(negedge clk200);
        cl_read[1]          = 1'b1;
        cl_address[20 +: 20] = 20'h00777;
        modelRdata          = 16'h4444;
        cl_req[1]           = ~cl_req[1];
        prevReq             = m_req;
        cycles              = 0;
        while (m_req === prevReq && cycles < 20) begin
            @(negedge clk200);
            cycles++;
        end
        checkOutput("abort issue seen", (m_req !== prevReq), 1);
        @(negedge clk200);
        @(negedge clk200);
        reset_n = 1'b0;
        #1;
        checkOutput("abort cl_ack", cl_ack, 0);
        checkOutput("abort m_req", m_req, 0);
        checkOutput("abort cl_rvalid", cl_rvalid, 0);
        checkOutput("abort cl_rdata", cl_rdata, 0);
        cl_req = '0;
        repeat (5) begin
            @(negedge clk200);
            checkOutput("abort held cl_ack", cl_ack, 0);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk200);
        checkOutput("post-reset idle", m_req, 0);
        applyStimulus(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
